// File: rtl/delay_timer_arbiter_if.sv
// Request/grant/ack bundle between the clients and the shared delay timer.
// master = requester side, slave = timer side.
interface delay_timer_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] ack;
    logic            busy;
    logic            err;

    modport master (
        output req,
        input  gnt,
        input  ack,
        input  busy,
        input  err
    );

    modport slave (
        input  req,
        output gnt,
        output ack,
        output busy,
        output err
    );
endinterface

// File: rtl/delay_timer_arbiter.sv
// One N-cycle delay timer shared round-robin among NREQ requesters; the owner
// gets a one-cycle ack once its delay has elapsed.
//
// state | meaning
// IDLE  | no owner; arbitrate among req starting at ptr
// RUN   | timer counting for owner; gnt asserted; abort if owner drops req
// DONE  | delay complete; ack issued next cycle, ptr moves past owner
module delay_timer_arbiter #(
    parameter int NREQ  = 4,
    parameter int N     = 1250,
    parameter int CBITS = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    delay_timer_arbiter_if.slave  bus
);
    localparam int               PBITS    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CBITS-1:0] CNT_LAST = CBITS'(N - 1);
    localparam logic [PBITS-1:0] IDX_LAST = PBITS'(NREQ - 1);
    localparam logic [PBITS:0]   NREQ_W   = (PBITS + 1)'(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CBITS-1:0]   cnt_q, cnt_d;
    logic [PBITS-1:0]   ptr_q, ptr_d;
    logic [PBITS-1:0]   owner_q, owner_d;
    logic [PBITS-1:0]   owner_nxt;
    logic [NREQ-1:0]    gnt_q, ack_q;
    logic               busy_q, err_q;

    logic               pick_vld;
    logic [PBITS-1:0]   pick_idx;
    logic [PBITS:0]     cand;

    function automatic logic [NREQ-1:0] onehot(input logic [PBITS-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

    // Scan offsets high to low so that offset 0 (ptr itself) ends up winning.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (PBITS + 1)'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (bus.req[cand[PBITS-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[PBITS-1:0];
            end
        end
    end

    assign owner_nxt = (owner_q == IDX_LAST) ? '0 : owner_q + PBITS'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.req[owner_q]) begin
                    ptr_d   = owner_nxt;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CBITS'(1);
                end
            end
            DONE: begin
                ptr_d   = owner_nxt;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state so gnt/busy line up with RUN/DONE;
    // ack is taken from the DONE cycle itself, landing in the dead IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= (state_d == RUN) ? onehot(owner_d) : '0;
            ack_q   <= (state_q == DONE) ? onehot(owner_q) : '0;
            busy_q  <= (state_d == RUN) || (state_d == DONE);
            err_q   <= (state_d == RUN) && (cnt_d > CNT_LAST);
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.ack  = ack_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Bench for delay_timer_arbiter with N=4, NREQ=4: per-cycle vector table plus
// an ack-order scoreboard for the fully contended case.
module tb_delay_timer_arbiter;
    localparam int NREQ  = 4;
    localparam int N     = 4;
    localparam int CBITS = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    delay_timer_arbiter_if #(.NREQ(NREQ)) bus ();

    delay_timer_arbiter #(.NREQ(NREQ), .N(N), .CBITS(CBITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       busy;
        int         tag;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    logic [3:0] ack_q_exp[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                                input logic [3:0] a, input logic b, input int tag);
        vec_t v;
        v.rst = r; v.req = rq; v.gnt = g; v.ack = a; v.busy = b; v.tag = tag;
        vecs.push_back(v);
    endfunction

    // One clock; outputs settle 1ns after the edge and invariants are checked.
    task automatic tick();
        @(posedge clk);
        #1;
        check("err_low", {31'b0, bus.err}, 32'd0);
        check("gnt_onehot0", {31'b0, $onehot0(bus.gnt)}, 32'd1);
        check("ack_onehot0", {31'b0, $onehot0(bus.ack)}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        int   last_ack;

        rst     = 1'b1;
        bus.req = '0;

        // 1: single requester, uncontended latency
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        add(0, 4'b0001, 4'b0001, 4'b0000, 1, 1);
        add(0, 4'b0001, 4'b0001, 4'b0000, 1, 1);
        add(0, 4'b0001, 4'b0001, 4'b0000, 1, 1);
        add(0, 4'b0001, 4'b0001, 4'b0000, 1, 1);
        add(0, 4'b0001, 4'b0000, 4'b0000, 1, 1);
        add(0, 4'b0000, 4'b0000, 4'b0001, 0, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        // 3: after bit0 is served, bit2 wins over bit0
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 3);
        add(0, 4'b0101, 4'b0001, 4'b0000, 1, 3);
        add(0, 4'b0101, 4'b0001, 4'b0000, 1, 3);
        add(0, 4'b0101, 4'b0001, 4'b0000, 1, 3);
        add(0, 4'b0101, 4'b0001, 4'b0000, 1, 3);
        add(0, 4'b0101, 4'b0000, 4'b0000, 1, 3);
        add(0, 4'b0101, 4'b0000, 4'b0001, 0, 3);
        add(0, 4'b0101, 4'b0100, 4'b0000, 1, 3);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 3);
        // 4: abort by bit1 after 2 RUN cycles, ptr moves to 2
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 4);
        add(0, 4'b0010, 4'b0010, 4'b0000, 1, 4);
        add(0, 4'b0010, 4'b0010, 4'b0000, 1, 4);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 4);
        add(0, 4'b0011, 4'b0001, 4'b0000, 1, 4);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 4);
        // 5: reset mid-RUN, rst wins over req, then full run to ack
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 5);
        add(0, 4'b0100, 4'b0100, 4'b0000, 1, 5);
        add(0, 4'b0100, 4'b0100, 4'b0000, 1, 5);
        add(0, 4'b0100, 4'b0100, 4'b0000, 1, 5);
        add(1, 4'b0100, 4'b0000, 4'b0000, 0, 5);
        add(0, 4'b0100, 4'b0100, 4'b0000, 1, 5);
        add(0, 4'b0100, 4'b0100, 4'b0000, 1, 5);
        add(0, 4'b0100, 4'b0100, 4'b0000, 1, 5);
        add(0, 4'b0100, 4'b0100, 4'b0000, 1, 5);
        add(0, 4'b0100, 4'b0000, 4'b0000, 1, 5);
        add(0, 4'b0000, 4'b0000, 4'b0100, 0, 5);
        // 6: reset in DONE suppresses ack and returns ptr to 0
        add(0, 4'b0001, 4'b0001, 4'b0000, 1, 6);
        add(0, 4'b0001, 4'b0001, 4'b0000, 1, 6);
        add(0, 4'b0001, 4'b0001, 4'b0000, 1, 6);
        add(0, 4'b0001, 4'b0001, 4'b0000, 1, 6);
        add(0, 4'b0001, 4'b0000, 4'b0000, 1, 6);
        add(1, 4'b0001, 4'b0000, 4'b0000, 0, 6);
        add(0, 4'b1111, 4'b0001, 4'b0000, 1, 6);
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 6);

        for (int i = 0; i < vecs.size(); i++) begin
            rst     = vecs[i].rst;
            bus.req = vecs[i].req;
            sb.push_back(vecs[i]);
            tick();
            e = sb.pop_front();
            check($sformatf("t%0d_v%0d_gnt", e.tag, i), {28'b0, bus.gnt}, {28'b0, e.gnt});
            check($sformatf("t%0d_v%0d_ack", e.tag, i), {28'b0, bus.ack}, {28'b0, e.ack});
            check($sformatf("t%0d_v%0d_busy", e.tag, i), {31'b0, bus.busy}, {31'b0, e.busy});
        end

        // 2: all requesters held; round-robin ack order with a 6-cycle period
        rst     = 1'b1;
        bus.req = '0;
        tick();
        rst     = 1'b0;
        bus.req = 4'b1111;
        ack_q_exp.push_back(4'b0001);
        ack_q_exp.push_back(4'b0010);
        ack_q_exp.push_back(4'b0100);
        ack_q_exp.push_back(4'b1000);
        ack_q_exp.push_back(4'b0001);
        last_ack = -1;
        for (int cyc = 0; cyc < 60 && ack_q_exp.size() > 0; cyc++) begin
            tick();
            if (bus.ack != 4'b0000) begin
                check("t2_ack_order", {28'b0, bus.ack}, {28'b0, ack_q_exp.pop_front()});
                if (last_ack >= 0) begin
                    check("t2_ack_period", cyc - last_ack, 32'd6);
                end else begin
                    check("t2_first_ack_cycle", cyc, 32'd5);
                end
                last_ack = cyc;
            end
        end
        check("t2_acks_pending", ack_q_exp.size(), 32'd0);
        bus.req = '0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
